// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-lane function codes, the accumulate-mode bit
// and the default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH    = 16;
    localparam int ACC_MODE_BIT = 3;

    typedef enum logic [2:0] {
        LOP_OR   = 3'd0,
        LOP_NOR  = 3'd1,
        LOP_AND  = 3'd2,
        LOP_NAND = 3'd3,
        LOP_XOR  = 3'd4,
        LOP_XNOR = 3'd5,
        LOP_NOT  = 3'd6,
        LOP_PASS = 3'd7
    } logic_op_e;

    function automatic logic is_acc_mode(input logic [3:0] op);
        return op[ACC_MODE_BIT];
    endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Upstream beat and downstream result handshake of the logic lane.
interface logic_unit_pipe_if #(
    parameter int WIDTH = alu_pkg::ALU_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             all_ones;
    logic [WIDTH-1:0] acc;

    modport master (
        output in_valid, a, b, op, acc_clr, out_ready,
        input  in_ready, out_valid, result, zero, all_ones, acc
    );

    modport slave (
        input  in_valid, a, b, op, acc_clr, out_ready,
        output in_ready, out_valid, result, zero, all_ones, acc
    );
endinterface

// File: rtl/logic_fifo.sv
// Generic WIDTH x DEPTH valid/ready buffer; head data reads as zero when empty.
module logic_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [DEPTH-1:0] wr_en;
    logic             push, pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push_ready = (count_reg < CNT_W'(DEPTH));
    assign pop_valid  = (count_reg != '0);
    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;
    assign pop_data   = pop_valid ? mem_reg[rd_ptr_reg] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_reg[i] <= push_data;
            end
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            count_reg <= count_next;
        end
    end
endmodule

// File: rtl/logic_unit_pipe.sv
// ALU logic lane: eight bitwise functions with optional accumulator operand,
// buffered behind a valid/ready output FIFO with zero / all-ones flags.
module logic_unit_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    logic_unit_pipe_if.slave  bus
);
    logic             accept;
    logic             acc_mode;
    logic             push_ready;
    logic             head_valid;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] op_result;
    logic [WIDTH-1:0] head_data;
    logic [WIDTH-1:0] acc_reg, acc_next;

    assign acc_mode = is_acc_mode(bus.op);
    assign accept   = bus.in_valid && push_ready;

    // A clear in accumulate mode takes effect before the accumulator is used.
    always_comb begin
        b_eff = bus.b;
        if (acc_mode) begin
            b_eff = bus.acc_clr ? '0 : acc_reg;
        end
    end

    always_comb begin
        op_result = '0;
        case (logic_op_e'(bus.op[2:0]))
            LOP_OR:   op_result = bus.a | b_eff;
            LOP_NOR:  op_result = ~(bus.a | b_eff);
            LOP_AND:  op_result = bus.a & b_eff;
            LOP_NAND: op_result = ~(bus.a & b_eff);
            LOP_XOR:  op_result = bus.a ^ b_eff;
            LOP_XNOR: op_result = ~(bus.a ^ b_eff);
            LOP_NOT:  op_result = ~bus.a;
            LOP_PASS: op_result = bus.a;
        endcase
    end

    always_comb begin
        acc_next = acc_reg;
        if (accept) begin
            if (acc_mode) begin
                acc_next = op_result;
            end else if (bus.acc_clr) begin
                acc_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    logic_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (bus.in_valid),
        .push_ready (push_ready),
        .push_data  (op_result),
        .pop_valid  (head_valid),
        .pop_ready  (bus.out_ready),
        .pop_data   (head_data)
    );

    assign bus.in_ready  = push_ready;
    assign bus.out_valid = head_valid;
    assign bus.result    = head_data;
    assign bus.zero      = (head_data == '0);
    assign bus.all_ones  = (head_data == '1);
    assign bus.acc       = acc_reg;
endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, handshaked successor to the single-function OR/NOR units. It adds the following:
- eight bitwise operations selected per beat;
- an optional accumulator operand mode;
- an output buffer of depth DEPTH with valid/ready flow control;
- zero and all-ones status flags.

It sits in the ALU datapath as the logic lane, alongside the arithmetic lanes. Its result feeds the ALU output mux.

Parameters:
WIDTH, 16, operand/result width in bits (>=1)
DEPTH, 2, output buffer entries (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream beat present
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B (ignored in accumulate mode)
op  input  4  op[2:0] function; op[3]=1 selects accumulate mode
acc_clr  input  1  clear accumulator; qualified by handshake
out_valid  output  1  result at buffer head
out_ready  input  1  downstream accepts head
result  output  WIDTH  head result
zero  output  1  head result == 0
all_ones  output  1  head result == all ones
acc  output  WIDTH  current accumulator value

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: buffer empty, out_valid=0, result=0, zero=1, all_ones=0, acc=0, in_ready=1.
- Accept: a beat is accepted on a rising edge where in_valid && in_ready.
- Release: the head is released on an edge where out_valid && out_ready.
- in_ready: in_ready = (count < DEPTH), decoded from registered count.
  - No same-cycle pass-through when full. With count==DEPTH, in_ready=0 even if out_ready=1.
- Operand B: B_eff = b when op[3]=0.
  - When op[3]=1: B_eff = 0 if acc_clr, else acc.
- Functions (on a, B_eff), by op[2:0]:
  - 0: OR
  - 1: NOR
  - 2: AND
  - 3: NAND
  - 4: XOR
  - 5: XNOR
  - 6: NOT a
  - 7: PASS a
- Latency: result is computed combinationally at accept and written to the buffer tail.
  - It appears at the head (out_valid=1) on the edge after acceptance when the buffer was empty: latency 1 cycle.
  - Otherwise the beat is FIFO-ordered behind older entries.
- Accumulator updates (acc is updated only on an accepted beat):
  - op[3]=1: acc <= computed result.
  - op[3]=0 with acc_clr=1: acc <= 0.
  - Otherwise acc holds.
- acc_clr handling:
  - acc_clr without an accepted beat has no effect.
  - acc_clr together with op[3]=1: the clear applies before use, so the operand is 0 and acc takes the result.
- Simultaneous push and pop (0<count<DEPTH): count unchanged; head advances and tail writes in the same edge.
- Pop when empty: impossible, since out_valid=0.
- Push when full: impossible, since in_ready=0.
- Pointers: read and write pointers wrap modulo DEPTH; DEPTH need not be a power of 2.
- Head outputs:
  - result is the head entry (0 when empty).
  - zero and all_ones are derived from the result output.
  - result holds stable while out_valid && !out_ready.
- Reset mid-operation: all buffered beats and acc are discarded immediately and asynchronously. Outputs go to their reset values without waiting for clk. Deassertion is synchronised externally.
- X safety: a, b and op are don't-care when in_valid=0 and must not corrupt state.

Decomposition:
- Shared package alu_pkg holds:
  - logic_op_e enum (LOP_OR=0 … LOP_PASS=7);
  - ACC_MODE_BIT=3;
  - the default ALU_WIDTH=16.
- One natural sub-module, logic_fifo: a generic WIDTH x DEPTH valid/ready buffer with count, pointers and async active-low reset.
- logic_unit_pipe itself contains the function decode, operand mux and accumulator.

Test Plan:
- Reset, then one beat {a=16'hF0F0, b=16'h0FF0, op=0} with out_ready=1 -> one cycle later out_valid=1, result=16'hFFF0, zero=0; next cycle out_valid=0.
- Sweep op[2:0]=0..7, one beat each, with a=16'h00FF, b=16'h0F0F -> results in order: 0FFF, F000, 000F, FFF0, 0FF0, F00F, FF00, 00FF; zero and all_ones never set.
- out_ready=0; push 3 beats with DEPTH=2 -> in_ready=0 after 2 accepts and the third beat stalls; raise out_ready -> results drain in order and the third beat is then accepted. No loss or duplication.
- Accumulate: beats {op=8+0, acc_clr=1, a=16'h0001}, {op=8+0, a=16'h0100}, {op=8+4, a=16'h0101} -> results 0001, 0101, 0000; acc ends 0; final zero=1.
- Backpressure hold: head result=16'hFFFF with out_ready=0 for 5 cycles -> result and all_ones=1 stable throughout.
- Assert rst_n low mid-stream with 2 entries buffered and acc=16'h1234 -> out_valid=0, acc=0, in_ready=1 immediately, before any clk edge.
